// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter generator.
//   pc_state_e           : BOOT / RUN / HALT sequencing states
//   PC_INC_16, PC_INC_32 : advance increments for 16-bit and 32-bit fetches
//   PC_DEFAULT_RESET_VEC : default value for pc_gen's RESET_VECTOR
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

   localparam int unsigned PC_INC_16 = 2;
   localparam int unsigned PC_INC_32 = 4;

   localparam logic [63:0] PC_DEFAULT_RESET_VEC = 64'h0;

endpackage

// File: rtl/pc_hist_shift.sv
// pc_hist_shift: HIST_DEPTH-deep history of XLEN-bit values.
//   clk, rst  : clock, async active-high reset (clears all entries)
//   shift_en  : push din into slot 0, older entries move up one slot
//   din       : value pushed on shift
//   hist      : flattened history, slot 0 in the LSBs is the most recent
module pc_hist_shift #(
   parameter int XLEN       = 32,
   parameter int HIST_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       shift_en,
   input  logic [XLEN-1:0]            din,
   output logic [HIST_DEPTH*XLEN-1:0] hist
);

   logic [HIST_DEPTH-1:0][XLEN-1:0] hist_q, hist_d;

   always_comb begin
      hist_d = hist_q;
      if (shift_en) begin
         hist_d[0] = din;
         for (int k = 1; k < HIST_DEPTH; k++) hist_d[k] = hist_q[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) hist_q <= '0;
      else     hist_q <= hist_d;
   end

   assign hist = hist_q;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with trap/redirect/stall control.
//   clk, rst            : clock, async active-high reset
//   trap_valid/_vector  : highest-priority redirect, never alignment checked
//   redirect_valid/_tgt : branch/jump redirect; a misaligned target halts
//   stall               : hold pc_out and history
//   inst_is_16          : current fetch is 16-bit (compressed build only)
//   fetch_ready         : imem accepted the fetch at pc_out
//   fetch_valid         : high only in RUN
//   pc_out, pc_hist     : current PC, previous PCs (slice 0 most recent)
//   misalign_err        : one-cycle pulse on a rejected redirect target
// Build option: define PC_COMPRESSED_EN for 16-bit instruction support
// (halfword alignment, +2 advance when inst_is_16).
module pc_gen
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = PC_DEFAULT_RESET_VEC[XLEN-1:0],
   parameter int              HIST_DEPTH   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       trap_valid,
   input  logic [XLEN-1:0]            trap_vector,
   input  logic                       redirect_valid,
   input  logic [XLEN-1:0]            redirect_target,
   input  logic                       stall,
   input  logic                       inst_is_16,
   input  logic                       fetch_ready,
   output logic                       fetch_valid,
   output logic [XLEN-1:0]            pc_out,
   output logic [HIST_DEPTH*XLEN-1:0] pc_hist,
   output logic                       misalign_err
);

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            err_q, err_d;
   logic            shift_en;
   logic [XLEN-1:0] inc;
   logic            tgt_misaligned;

`ifdef PC_COMPRESSED_EN
   assign inc            = inst_is_16 ? XLEN'(PC_INC_16) : XLEN'(PC_INC_32);
   assign tgt_misaligned = redirect_target[0];
`else
   logic unused_inst_is_16;
   assign unused_inst_is_16 = inst_is_16;
   assign inc               = XLEN'(PC_INC_32);
   assign tgt_misaligned    = |redirect_target[1:0];
`endif

   always_comb begin
      // BOOT always leaves after one edge, whatever else happens.
      state_d  = (state_q == BOOT) ? RUN : state_q;
      pc_d     = pc_q;
      err_d    = 1'b0;
      shift_en = 1'b0;
      if (trap_valid) begin
         pc_d     = trap_vector;
         state_d  = RUN;
         shift_en = 1'b1;
      end else if (redirect_valid && state_q != HALT) begin
         if (tgt_misaligned) begin
            err_d   = 1'b1;
            state_d = HALT;
         end else begin
            pc_d     = redirect_target;
            state_d  = RUN;
            shift_en = 1'b1;
         end
      end else if (!stall && state_q == RUN && fetch_ready) begin
         pc_d     = pc_q + inc;  // wraps modulo 2^XLEN
         shift_en = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         err_q   <= err_d;
      end
   end

   pc_hist_shift #(.XLEN(XLEN), .HIST_DEPTH(HIST_DEPTH)) u_hist (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en),
      .din      (pc_q),
      .hist     (pc_hist)
   );

   assign fetch_valid  = (state_q == RUN);
   assign pc_out       = pc_q;
   assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed + randomized check of pc_gen against a behavioural model.
module tb_pc_gen;
   localparam int XLEN = 32;
   localparam int HD   = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 trap_valid, redirect_valid, stall, inst_is_16, fetch_ready;
   logic [XLEN-1:0]      trap_vector, redirect_target;
   logic                 fetch_valid, misalign_err;
   logic [XLEN-1:0]      pc_out;
   logic [HD*XLEN-1:0]   pc_hist;

   always #5 clk = ~clk;

   pc_gen #(.XLEN(XLEN), .RESET_VECTOR(32'h0), .HIST_DEPTH(HD)) dut (
      .clk(clk), .rst(rst),
      .trap_valid(trap_valid), .trap_vector(trap_vector),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .stall(stall), .inst_is_16(inst_is_16), .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid), .pc_out(pc_out), .pc_hist(pc_hist),
      .misalign_err(misalign_err)
   );

   int errs = 0, checks = 0;

   // model: mode 0 = booting, 1 = fetching, 2 = halted
   int              m_mode;
   logic [XLEN-1:0] m_pc;
   logic [XLEN-1:0] m_hist [HD];
   bit              m_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit bad_target(input logic [XLEN-1:0] t);
`ifdef PC_COMPRESSED_EN
      return (t % 2) != 0;
`else
      return (t % 4) != 0;
`endif
   endfunction

   function automatic logic [XLEN-1:0] step_size();
`ifdef PC_COMPRESSED_EN
      return inst_is_16 ? 2 : 4;
`else
      return 4;
`endif
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pc = '0; m_err = 0;
      for (int k = 0; k < HD; k++) m_hist[k] = '0;
   endtask

   task automatic model_step();
      int              nm;
      bit              load;
      logic [XLEN-1:0] npc;
      nm = (m_mode == 0) ? 1 : m_mode;
      load = 0; npc = m_pc; m_err = 0;
      if (trap_valid) begin
         npc = trap_vector; nm = 1; load = 1;
      end else if (redirect_valid && m_mode != 2) begin
         if (bad_target(redirect_target)) begin m_err = 1; nm = 2; end
         else begin npc = redirect_target; nm = 1; load = 1; end
      end else if (!stall && m_mode == 1 && fetch_ready) begin
         npc = m_pc + step_size(); load = 1;
      end
      if (load) begin
         for (int k = HD-1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = m_pc;
      end
      m_pc = npc; m_mode = nm;
   endtask

   task automatic check_all(input string tag);
      logic [HD*XLEN-1:0] f;
      for (int k = 0; k < HD; k++) f[k*XLEN +: XLEN] = m_hist[k];
      chk({tag, ".pc"},   64'(pc_out),       64'(m_pc));
      chk({tag, ".fv"},   64'(fetch_valid),  64'(m_mode == 1));
      chk({tag, ".err"},  64'(misalign_err), 64'(m_err));
      chk({tag, ".hist"}, 64'(pc_hist),      64'(f));
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic idle_inputs();
      trap_valid = 0; redirect_valid = 0; stall = 0; inst_is_16 = 0;
      fetch_ready = 0; trap_vector = '0; redirect_target = '0;
   endtask

   // Reset asserted away from the clock edge, so it acts asynchronously.
   task automatic do_reset();
      #2 rst = 1'b1;
      idle_inputs();
      #1;
      model_reset();
      chk("rst.pc",   64'(pc_out),       64'h0);
      chk("rst.hist", 64'(pc_hist),      64'h0);
      chk("rst.fv",   64'(fetch_valid),  64'h0);
      chk("rst.err",  64'(misalign_err), 64'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      do_reset();

      // release with fetch_ready held: 0, 0, 4, 8
      fetch_ready = 1;
      chk("boot.fv0", 64'(fetch_valid), 64'h0);
      cycle("boot1"); chk("boot1.pc", 64'(pc_out), 64'h0); chk("boot1.fv", 64'(fetch_valid), 64'h1);
      cycle("boot2"); chk("boot2.pc", 64'(pc_out), 64'h4);
      cycle("boot3"); chk("boot3.pc", 64'(pc_out), 64'h8);

      // stall at 0x10
      redirect_valid = 1; redirect_target = 32'h10;
      cycle("rd10");
      redirect_valid = 0; stall = 1;
      for (int i = 0; i < 3; i++) begin
         cycle("stall"); chk("stall.pc", 64'(pc_out), 64'h10);
         chk("stall.hist0", 64'(pc_hist[XLEN-1:0]), 64'h8);
      end
      stall = 0;
      cycle("unstall");
      chk("unstall.pc", 64'(pc_out), 64'h14);
      chk("unstall.hist0", 64'(pc_hist[XLEN-1:0]), 64'h10);

      // trap beats redirect
      trap_valid = 1; trap_vector = 32'h80; redirect_valid = 1; redirect_target = 32'h40;
      cycle("prio"); chk("prio.pc", 64'(pc_out), 64'h80);
      trap_valid = 0; redirect_valid = 0;

`ifndef PC_COMPRESSED_EN
      redirect_valid = 1; redirect_target = 32'h42;
      cycle("mis"); chk("mis.err", 64'(misalign_err), 64'h1); chk("mis.fv", 64'(fetch_valid), 64'h0);
      chk("mis.pc", 64'(pc_out), 64'h80);
      redirect_target = 32'h40;
      cycle("halt"); chk("halt.err", 64'(misalign_err), 64'h0); chk("halt.pc", 64'(pc_out), 64'h80);
      redirect_valid = 0; trap_valid = 1; trap_vector = 32'h100;
      cycle("htrap"); chk("htrap.pc", 64'(pc_out), 64'h100); chk("htrap.fv", 64'(fetch_valid), 64'h1);
      trap_valid = 0;
`else
      redirect_valid = 1; redirect_target = 32'h20;
      cycle("rd20");
      redirect_valid = 0; inst_is_16 = 1;
      cycle("c16"); chk("c16.pc", 64'(pc_out), 64'h22);
      inst_is_16 = 0; redirect_valid = 1; redirect_target = 32'h42;
      cycle("rd42"); chk("rd42.pc", 64'(pc_out), 64'h42); chk("rd42.err", 64'(misalign_err), 64'h0);
      redirect_valid = 0;
`endif

      // wrap-around
      redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
      cycle("rdtop");
      redirect_valid = 0;
      cycle("wrap"); chk("wrap.pc", 64'(pc_out), 64'h0); chk("wrap.err", 64'(misalign_err), 64'h0);

      // reset while halted/stalled, then randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         trap_valid      = ($urandom_range(0, 15) == 0);
         trap_vector     = $urandom;
         redirect_valid  = ($urandom_range(0, 7) == 0);
         redirect_target = $urandom;
         if ($urandom_range(0, 3) != 0) redirect_target[1:0] = 2'b00;
         stall           = ($urandom_range(0, 3) == 0);
         fetch_ready     = ($urandom_range(0, 3) != 0);
         inst_is_16      = 1'($urandom);
         cycle("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
